// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  // Owner of the access currently in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  // Counter width able to hold 0..max; never narrower than one bit.
  function automatic int unsigned starve_cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of back-to-back data grants made while a fetch waits.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = starve_cnt_width(STARVE_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_max_int;

  assign at_max_int = (cnt_q == CW'(STARVE_MAX));
  assign at_max     = at_max_int;

  // Next count: clear dominates, increment stops at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max_int) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one memory between fetch (IF) and
// data (MEM) stages. Data wins ties unless fetch has been starved.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          StallIF,
  output logic          StallMEM
);

  arb_state_e    state_q,     state_d;
  arb_owner_e    owner_q,     owner_d;
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
  logic          if_ready_q,  if_ready_d;
  logic          dm_ready_q,  dm_ready_d;

  logic starve_inc;
  logic starve_clr;
  logic starve_at_max;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // Grant decision, access tracking and response generation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Any idle cycle without a pending fetch resets the starvation run.
        starve_clr = !if_req;
        if (dm_req && (!if_req || !starve_at_max)) begin
          state_d     = ST_BUSY_DM;
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          starve_inc  = if_req;
        end else if (if_req) begin
          state_d     = ST_BUSY_IF;
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          starve_clr  = 1'b1;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (mem_ack) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

  // Stalls drop in the ready cycle so the pipeline advances on that edge
  assign StallIF  = if_req & ~if_ready_q;
  assign StallMEM = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          StallIF;
  logic          StallMEM;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  mem_arbiter #(
    .STARVE_MAX (2),
    .AW         (AW),
    .DW         (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .StallIF   (StallIF),
    .StallMEM  (StallMEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start of a cycle: just after the rising edge, where inputs are driven
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic look();
    #2;
  endtask

  task automatic chk_state(input string tag, input arb_state_e exp);
    chk(tag, 64'(dut.state_q), 64'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int unsigned exp);
    chk(tag, 64'(dut.u_starve.cnt_q), 64'(exp));
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk_state({pfx, "_state"}, ST_IDLE);
    chk_cnt({pfx, "_cnt"}, 0);
    chk({pfx, "_mem_req"},   64'(mem_req),   64'd0);
    chk({pfx, "_mem_we"},    64'(mem_we),    64'd0);
    chk({pfx, "_if_ready"},  64'(if_ready),  64'd0);
    chk({pfx, "_dm_ready"},  64'(dm_ready),  64'd0);
    chk({pfx, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({pfx, "_if_rdata"},  64'(if_rdata),  64'd0);
    chk({pfx, "_dm_rdata"},  64'(dm_rdata),  64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    repeat (3) cyc();
    look();
    chk_reset_vals("rst");
    cyc(); reset = 1'b0; look();
    chk_state("post_rst_idle", ST_IDLE);

    // Lone fetch, zero-wait memory
    cyc(); if_req = 1'b1; if_addr = 32'h0040_0000; look();
    chk("t1c0_stallif", 64'(StallIF), 64'd1);
    chk("t1c0_mem_req", 64'(mem_req), 64'd0);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h2010_0005; look();
    chk("t1c1_mem_req",  64'(mem_req),  64'd1);
    chk("t1c1_mem_addr", 64'(mem_addr), 64'h0040_0000);
    chk("t1c1_mem_we",   64'(mem_we),   64'd0);
    chk("t1c1_stallif",  64'(StallIF),  64'd1);
    chk("t1c1_if_ready", 64'(if_ready), 64'd0);
    cyc(); mem_ack = 1'b0; mem_rdata = '0; look();
    chk("t1c2_if_ready", 64'(if_ready), 64'd1);
    chk("t1c2_if_rdata", 64'(if_rdata), 64'h2010_0005);
    chk("t1c2_stallif",  64'(StallIF),  64'd0);
    chk("t1c2_mem_req",  64'(mem_req),  64'd0);
    chk_state("t1c2_state", ST_RESP);
    cyc(); if_req = 1'b0; look();
    chk("t1c3_if_ready", 64'(if_ready), 64'd0);
    chk_state("t1c3_state", ST_IDLE);

    // Simultaneous requests with counter at 0: data first, then fetch
    cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0004;
    if_req = 1'b1; if_addr = 32'h0040_0004;
    look();
    chk_state("t2c0_state", ST_IDLE);
    chk_cnt("t2c0_cnt", 0);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h1234_5678; look();
    chk_state("t2c1_state", ST_BUSY_DM);
    chk_cnt("t2c1_cnt", 1);
    chk("t2c1_mem_addr", 64'(mem_addr), 64'h1000_0004);
    chk("t2c1_stallif",  64'(StallIF),  64'd1);
    chk("t2c1_stallmem", 64'(StallMEM), 64'd1);
    cyc(); mem_ack = 1'b0; look();
    chk("t2c2_dm_ready", 64'(dm_ready), 64'd1);
    chk("t2c2_dm_rdata", 64'(dm_rdata), 64'h1234_5678);
    chk("t2c2_stallmem", 64'(StallMEM), 64'd0);
    chk("t2c2_stallif",  64'(StallIF),  64'd1);
    chk("t2c2_if_ready", 64'(if_ready), 64'd0);
    cyc(); dm_req = 1'b0; look();
    chk_state("t2c3_state", ST_IDLE);
    chk_cnt("t2c3_cnt", 1);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555; look();
    chk_state("t2c4_state", ST_BUSY_IF);
    chk_cnt("t2c4_cnt", 0);
    chk("t2c4_mem_addr", 64'(mem_addr), 64'h0040_0004);
    chk("t2c4_mem_we",   64'(mem_we),   64'd0);
    cyc(); mem_ack = 1'b0; look();
    chk("t2c5_if_ready", 64'(if_ready), 64'd1);
    chk("t2c5_if_rdata", 64'(if_rdata), 64'hAAAA_5555);
    chk("t2c5_dm_rdata", 64'(dm_rdata), 64'h1234_5678);
    cyc(); if_req = 1'b0; look();
    chk_state("t2c6_state", ST_IDLE);

    // Starvation guard with STARVE_MAX=2: DM, DM, then IF
    cyc();
    if_req = 1'b1; if_addr = 32'h0040_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0010;
    look();
    chk_state("t3_start_state", ST_IDLE);
    chk_cnt("t3_start_cnt", 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_ack = 1'b1; mem_rdata = 32'hC000_0000 + 32'(i); look();
      chk_state($sformatf("t3_%0d_busy", i), (i < 2) ? ST_BUSY_DM : ST_BUSY_IF);
      chk_cnt($sformatf("t3_%0d_cnt", i), (i < 2) ? i + 1 : 0);
      chk($sformatf("t3_%0d_mem_addr", i), 64'(mem_addr),
          (i < 2) ? 64'h1000_0010 : 64'h0040_0008);
      cyc(); mem_ack = 1'b0; look();
      chk($sformatf("t3_%0d_if_ready", i), 64'(if_ready), (i == 2) ? 64'd1 : 64'd0);
      chk($sformatf("t3_%0d_dm_ready", i), 64'(dm_ready), (i < 2) ? 64'd1 : 64'd0);
      chk($sformatf("t3_%0d_stallif", i), 64'(StallIF), (i < 2) ? 64'd1 : 64'd0);
      if (i == 2) chk("t3_if_rdata", 64'(if_rdata), 64'hC000_0002);
      else chk($sformatf("t3_%0d_dm_rdata", i), 64'(dm_rdata), 64'hC000_0000 + 64'(i));
      cyc();
      if (i == 2) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      look();
      chk_state($sformatf("t3_%0d_idle", i), ST_IDLE);
    end
    chk_cnt("t3_end_cnt", 0);

    // Store with three busy cycles before the ack
    cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1000_0008; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hFFFF_0000;
    look();
    chk_state("t4c0_state", ST_IDLE);
    for (int k = 0; k < 3; k++) begin
      cyc(); mem_ack = (k == 2); look();
      chk_state($sformatf("t4_b%0d_state", k), ST_BUSY_DM);
      chk($sformatf("t4_b%0d_mem_req", k),   64'(mem_req),   64'd1);
      chk($sformatf("t4_b%0d_mem_we", k),    64'(mem_we),    64'd1);
      chk($sformatf("t4_b%0d_mem_addr", k),  64'(mem_addr),  64'h1000_0008);
      chk($sformatf("t4_b%0d_mem_wdata", k), 64'(mem_wdata), 64'hDEAD_BEEF);
      chk($sformatf("t4_b%0d_dm_ready", k),  64'(dm_ready),  64'd0);
    end
    cyc(); mem_ack = 1'b0; look();
    chk("t4_dm_ready", 64'(dm_ready), 64'd1);
    chk("t4_dm_rdata", 64'(dm_rdata), 64'hC000_0001);
    cyc(); dm_req = 1'b0; dm_we = 1'b0; look();
    chk("t4_dm_ready_off", 64'(dm_ready), 64'd0);
    chk("t4_dm_rdata_hold", 64'(dm_rdata), 64'hC000_0001);
    chk("t4_mem_req_off", 64'(mem_req), 64'd0);

    // Stray ack while idle is ignored
    cyc(); mem_ack = 1'b1; look();
    chk_state("idle_ack_state", ST_IDLE);
    cyc(); mem_ack = 1'b0; look();
    chk_state("idle_ack_state2", ST_IDLE);
    chk("idle_ack_dm_ready", 64'(dm_ready), 64'd0);
    chk("idle_ack_if_ready", 64'(if_ready), 64'd0);
    chk("idle_ack_mem_req",  64'(mem_req),  64'd0);

    // Reset sampled mid-access abandons it
    cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0020; look();
    chk_state("t5c0_state", ST_IDLE);
    cyc(); reset = 1'b1; look();
    chk_state("t5c1_state", ST_BUSY_DM);
    chk("t5c1_mem_req", 64'(mem_req), 64'd1);
    cyc(); reset = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA; look();
    chk_reset_vals("t5c2");
    cyc(); mem_ack = 1'b0; look();
    chk("t5c3_dm_ready", 64'(dm_ready), 64'd0);
    chk("t5c3_if_ready", 64'(if_ready), 64'd0);
    chk("t5c3_dm_rdata", 64'(dm_rdata), 64'd0);
    chk_state("t5c3_state", ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
